// File: rtl/true_dual_ram_if.sv
`default_nettype none
// ============================================================================
//  Module      : true_dual_ram_if
//  Description : Port bundle for true_dual_ram: two byte-enabled read/write
//                ports plus the write-write collision status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface true_dual_ram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
);
    logic                  a_cs;
    logic                  a_we;
    logic                  a_re;
    logic [ADDR_W-1:0]     a_addr;
    logic [DATA_W-1:0]     a_wdata;
    logic [DATA_W/8-1:0]   a_be;
    logic [DATA_W-1:0]     a_rdata;
    logic                  a_rvalid;

    logic                  b_cs;
    logic                  b_we;
    logic                  b_re;
    logic [ADDR_W-1:0]     b_addr;
    logic [DATA_W-1:0]     b_wdata;
    logic [DATA_W/8-1:0]   b_be;
    logic [DATA_W-1:0]     b_rdata;
    logic                  b_rvalid;

    logic                  coll;
    logic [CNT_W-1:0]      coll_cnt;

    modport master (
        output a_cs, a_we, a_re, a_addr, a_wdata, a_be,
        output b_cs, b_we, b_re, b_addr, b_wdata, b_be,
        input  a_rdata, a_rvalid, b_rdata, b_rvalid, coll, coll_cnt
    );

    modport slave (
        input  a_cs, a_we, a_re, a_addr, a_wdata, a_be,
        input  b_cs, b_we, b_re, b_addr, b_wdata, b_be,
        output a_rdata, a_rvalid, b_rdata, b_rvalid, coll, coll_cnt
    );
endinterface
`default_nettype wire

// File: rtl/true_dual_ram.sv
`default_nettype none
// ============================================================================
//  Module      : true_dual_ram
//  Description : Single-clock true dual-port RAM with byte enables, old-data
//                read-during-write, port-A-priority write collisions and a
//                saturating collision counter. Define TRUE_DUAL_RAM_OUTREG_EN
//                to add a second output register stage (read latency 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module true_dual_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    true_dual_ram_if.slave     bus
);

    localparam int               c_DEPTH   = 2 ** ADDR_W;
    localparam int               c_NBYTES  = DATA_W / 8;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic              w_a_wr;
    logic              w_a_rd;
    logic              w_b_wr;
    logic              w_b_rd;
    logic              w_coll;

    logic [DATA_W-1:0] r_a_rdata;
    logic              r_a_rvalid;
    logic [DATA_W-1:0] r_b_rdata;
    logic              r_b_rvalid;
    logic              r_coll;
    logic [CNT_W-1:0]  r_coll_cnt;

    // Gating with rst_n keeps the unreset memory array untouched while in reset.
    assign w_a_wr = rst_n & bus.a_cs & bus.a_we;
    assign w_a_rd = rst_n & bus.a_cs & bus.a_re;
    assign w_b_wr = rst_n & bus.b_cs & bus.b_we;
    assign w_b_rd = rst_n & bus.b_cs & bus.b_re;
    assign w_coll = w_a_wr & w_b_wr & (bus.a_addr == bus.b_addr);

    // Port A is written last so it overrides port B on overlapping bytes.
    always_ff @(posedge clk) begin : p_mem
        for (int i = 0; i < c_NBYTES; i++) begin
            if (w_b_wr && bus.b_be[i]) begin
                r_mem[bus.b_addr][i*8 +: 8] <= bus.b_wdata[i*8 +: 8];
            end
            if (w_a_wr && bus.a_be[i]) begin
                r_mem[bus.a_addr][i*8 +: 8] <= bus.a_wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_read
        if (!rst_n) begin
            r_a_rdata  <= '0;
            r_a_rvalid <= 1'b0;
            r_b_rdata  <= '0;
            r_b_rvalid <= 1'b0;
        end else begin
            r_a_rvalid <= w_a_rd;
            r_b_rvalid <= w_b_rd;
            if (w_a_rd) begin
                r_a_rdata <= r_mem[bus.a_addr];
            end
            if (w_b_rd) begin
                r_b_rdata <= r_mem[bus.b_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_coll
        if (!rst_n) begin
            r_coll     <= 1'b0;
            r_coll_cnt <= '0;
        end else begin
            r_coll <= w_coll;
            if (w_coll && (r_coll_cnt != c_CNT_MAX)) begin
                r_coll_cnt <= r_coll_cnt + c_CNT_ONE;
            end
        end
    end

    assign bus.coll     = r_coll;
    assign bus.coll_cnt = r_coll_cnt;

`ifdef TRUE_DUAL_RAM_OUTREG_EN
    logic [DATA_W-1:0] r_a_rdata_q;
    logic              r_a_rvalid_q;
    logic [DATA_W-1:0] r_b_rdata_q;
    logic              r_b_rvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin : p_outreg
        if (!rst_n) begin
            r_a_rdata_q  <= '0;
            r_a_rvalid_q <= 1'b0;
            r_b_rdata_q  <= '0;
            r_b_rvalid_q <= 1'b0;
        end else begin
            r_a_rvalid_q <= r_a_rvalid;
            r_b_rvalid_q <= r_b_rvalid;
            if (r_a_rvalid) begin
                r_a_rdata_q <= r_a_rdata;
            end
            if (r_b_rvalid) begin
                r_b_rdata_q <= r_b_rdata;
            end
        end
    end

    assign bus.a_rdata  = r_a_rdata_q;
    assign bus.a_rvalid = r_a_rvalid_q;
    assign bus.b_rdata  = r_b_rdata_q;
    assign bus.b_rvalid = r_b_rvalid_q;
`else
    assign bus.a_rdata  = r_a_rdata;
    assign bus.a_rvalid = r_a_rvalid;
    assign bus.b_rdata  = r_b_rdata;
    assign bus.b_rvalid = r_b_rvalid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_true_dual_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_true_dual_ram
//  Description : Randomized plus directed bench for true_dual_ram against a
//                word-level memory model with a read-latency queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_true_dual_ram;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int CW    = 2;
    localparam int DEPTH = 2 ** AW;
    localparam int CMAX  = 2 ** CW - 1;
`ifdef TRUE_DUAL_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    true_dual_ram_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

    true_dual_ram #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    int            m_cnt;
    bit            qa_v[$];
    bit            qb_v[$];
    logic [DW-1:0] qa_d[$];
    logic [DW-1:0] qb_d[$];
    logic [DW-1:0] e_ard, e_brd;
    bit            e_arv, e_brv, e_coll;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] be_mask(input logic [DW/8-1:0] be);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < DW/8; i++) begin
            if (be[i]) m[i*8 +: 8] = 8'hFF;
        end
        return m;
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        qa_v.delete(); qb_v.delete(); qa_d.delete(); qb_d.delete();
        for (int i = 0; i < LAT - 1; i++) begin
            qa_v.push_back(1'b0); qb_v.push_back(1'b0);
            qa_d.push_back('0);   qb_d.push_back('0);
        end
        e_ard = '0; e_brd = '0; e_arv = 1'b0; e_brv = 1'b0; e_coll = 1'b0;
    endtask

    task automatic check_outs();
        chk("a_rvalid", bus.a_rvalid, e_arv);
        chk("b_rvalid", bus.b_rvalid, e_brv);
        chk("a_rdata",  bus.a_rdata,  e_ard);
        chk("b_rdata",  bus.b_rdata,  e_brd);
        chk("coll",     bus.coll,     e_coll);
        chk("coll_cnt", bus.coll_cnt, m_cnt);
    endtask

    task automatic set_a(input bit cs, input bit we, input bit re, input int addr,
                         input logic [DW-1:0] wd, input logic [DW/8-1:0] be);
        bus.a_cs = cs; bus.a_we = we; bus.a_re = re;
        bus.a_addr = AW'(addr); bus.a_wdata = wd; bus.a_be = be;
    endtask

    task automatic set_b(input bit cs, input bit we, input bit re, input int addr,
                         input logic [DW-1:0] wd, input logic [DW/8-1:0] be);
        bus.b_cs = cs; bus.b_we = we; bus.b_re = re;
        bus.b_addr = AW'(addr); bus.b_wdata = wd; bus.b_be = be;
    endtask

    task automatic idle();
        set_a(0, 0, 0, 0, '0, '0);
        set_b(0, 0, 0, 0, '0, '0);
    endtask

    // One clock edge: model evaluates the sampled inputs, then outputs are checked.
    task automatic cycle();
        bit            av, bv, aw, bw;
        logic [DW-1:0] ad, bd, ma, mb, d;
        @(posedge clk);
        aw = rst_n && bus.a_cs && bus.a_we;
        bw = rst_n && bus.b_cs && bus.b_we;
        av = rst_n && bus.a_cs && bus.a_re;
        bv = rst_n && bus.b_cs && bus.b_re;
        ad = m_mem[bus.a_addr];
        bd = m_mem[bus.b_addr];
        ma = aw ? be_mask(bus.a_be) : '0;
        mb = bw ? be_mask(bus.b_be) : '0;
        e_coll = aw && bw && (bus.a_addr == bus.b_addr);
        if (e_coll) begin
            m_mem[bus.a_addr] = (bus.a_wdata & ma) | (bus.b_wdata & mb & ~ma)
                              | (m_mem[bus.a_addr] & ~(ma | mb));
            if (m_cnt < CMAX) m_cnt++;
        end else begin
            if (aw) m_mem[bus.a_addr] = (bus.a_wdata & ma) | (m_mem[bus.a_addr] & ~ma);
            if (bw) m_mem[bus.b_addr] = (bus.b_wdata & mb) | (m_mem[bus.b_addr] & ~mb);
        end
        qa_v.push_back(av); qa_d.push_back(ad);
        qb_v.push_back(bv); qb_d.push_back(bd);
        e_arv = qa_v.pop_front(); d = qa_d.pop_front(); if (e_arv) e_ard = d;
        e_brv = qb_v.pop_front(); d = qb_d.pop_front(); if (e_brv) e_brd = d;
        #1;
        check_outs();
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outs();
    endtask

    task automatic drain();
        idle();
        repeat (LAT - 1) cycle();
    endtask

    initial begin
        idle();
        model_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check_outs();
        set_a(1, 1, 1, 1, 32'hFFFF_FFFF, 4'hF);
        repeat (2) cycle();
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH / 2; i++) begin
            set_a(1, 1, 0, i,             $urandom, 4'hF);
            set_b(1, 1, 0, i + DEPTH / 2, $urandom, 4'hF);
            cycle();
        end

        // Write then read on the other port
        idle(); set_a(1, 1, 0, 'h10, 32'hDEADBEEF, 4'hF); cycle();
        idle(); set_b(1, 0, 1, 'h10, '0, '0);              cycle();
        drain();
        chk("r036_data",  bus.b_rdata,  32'hDEADBEEF);
        chk("r036_valid", bus.b_rvalid, 1'b1);

        // Byte-enable merge
        idle(); set_a(1, 1, 0, 5, 32'h11223344, 4'hF);   cycle();
        set_a(1, 1, 0, 5, 32'hAABBCCDD, 4'b0101);        cycle();
        set_a(1, 0, 1, 5, '0, '0);                       cycle();
        drain();
        chk("r037_data", bus.a_rdata, 32'h11BB33DD);

        // Same-address dual write
        set_a(1, 1, 0, 3, 32'hAAAAAAAA, 4'b0011);
        set_b(1, 1, 0, 3, 32'h55555555, 4'hF);
        cycle();
        chk("r038_coll", bus.coll,     1'b1);
        chk("r038_cnt",  bus.coll_cnt, 1);
        idle(); set_a(1, 0, 1, 3, '0, '0); cycle();
        chk("r038_coll_off", bus.coll, 1'b0);
        drain();
        chk("r038_data", bus.a_rdata, 32'h5555AAAA);

        // Read on B while A writes the same address
        idle(); set_a(1, 1, 0, 7, 32'h0, 4'hF); cycle();
        set_a(1, 1, 0, 7, 32'h12345678, 4'hF);
        set_b(1, 0, 1, 7, '0, '0);
        cycle();
        drain();
        chk("r039_old", bus.b_rdata, 32'h0);
        idle(); set_b(1, 0, 1, 7, '0, '0); cycle();
        drain();
        chk("r039_new", bus.b_rdata, 32'h12345678);

        // Reset with reads pending; writes presented in reset must be ignored
        idle();
        set_a(1, 0, 1, 'h10, '0, '0);
        set_b(1, 0, 1, 5, '0, '0);
        cycle();
        set_b(1, 1, 0, 'h10, 32'h0, 4'hF);
        async_reset();
        chk("r041_arv", bus.a_rvalid, 1'b0);
        chk("r041_ard", bus.a_rdata,  32'h0);
        cycle();
        rst_n = 1'b1;
        idle();
        repeat (3) cycle();
        set_a(1, 0, 1, 'h10, '0, '0); cycle();
        drain();
        chk("r041_mem", bus.a_rdata, 32'hDEADBEEF);

        // Counter saturation
        for (int i = 0; i < 5; i++) begin
            set_a(1, 1, 0, 9, $urandom, 4'($urandom));
            set_b(1, 1, 0, 9, $urandom, 4'($urandom));
            cycle();
            chk("r040_cnt", bus.coll_cnt, (i + 1 > CMAX) ? CMAX : i + 1);
        end
        idle(); cycle();
        chk("r040_hold", bus.coll_cnt, CMAX);

        // Random traffic, occasional async reset
        for (int n = 0; n < 400; n++) begin
            int aa, ba;
            aa = $urandom_range(DEPTH - 1);
            ba = ($urandom_range(3) == 0) ? aa : $urandom_range(DEPTH - 1);
            set_a($urandom_range(3) != 0, $urandom_range(1), $urandom_range(1), aa,
                  $urandom, 4'($urandom));
            set_b($urandom_range(3) != 0, $urandom_range(1), $urandom_range(1), ba,
                  $urandom, 4'($urandom));
            if ($urandom_range(60) == 0) begin
                async_reset();
                cycle();
                rst_n = 1'b1;
            end else begin
                cycle();
            end
        end

        idle();
        repeat (3) cycle();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/true_dual_ram.md
TRUE_DUAL_RAM -- requirements
Module: true_dual_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter ADDR_W, default 8, address width; depth = 2**ADDR_W words.
REQ-003 SHALL have parameter CNT_W, default 16, collision counter width.
REQ-004 SHALL have port clk, input, 1, single clock for all ports; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports a_cs and b_cs, input, 1 each, port chip select.
REQ-007 SHALL have ports a_we and b_we, input, 1 each, write enable.
REQ-008 SHALL have ports a_re and b_re, input, 1 each, read enable.
REQ-009 SHALL have ports a_addr and b_addr, input, ADDR_W each, word address.
REQ-010 SHALL have ports a_wdata and b_wdata, input, DATA_W each, write data.
REQ-011 SHALL have ports a_be and b_be, input, DATA_W/8 each, byte enables; bit i gates byte i.
REQ-012 SHALL have ports a_rdata and b_rdata, output, DATA_W each, read data.
REQ-013 SHALL have ports a_rvalid and b_rvalid, output, 1 each, read data valid.
REQ-014 SHALL have port coll, output, 1, write-write collision pulse.
REQ-015 SHALL have port coll_cnt, output, CNT_W, saturating collision count.

Function
REQ-016 A port SHALL act only when its cs=1; with cs=0, we/re on that port are ignored.
REQ-017 A write SHALL update only the bytes whose be bit is 1; be=0 writes nothing.
REQ-018 A read issued at edge N SHALL drive rdata at edge N+1 with rvalid=1 for exactly that cycle.
REQ-019 With no read issued, rvalid SHALL be 0 and rdata SHALL hold its last value.
REQ-020 Read-during-write, same port, same address: read SHALL return the pre-write (old) data.
REQ-021 Read on one port, write on the other, same address, same edge: read SHALL return the old data.
REQ-022 Both ports writing the same address on the same edge: port A bytes SHALL win where a_be=1; port B bytes SHALL land where a_be=0 and b_be=1.
REQ-023 Such a same-address dual write SHALL assert coll for one cycle (edge N+1), independent of byte enables.
REQ-024 coll_cnt SHALL increment by 1 per collision and saturate at 2**CNT_W-1 without wrapping.
REQ-025 Writes to different addresses on both ports in the same cycle SHALL both complete with no coll.
REQ-026 Addresses SHALL cover the full 0..2**ADDR_W-1 range with no aliasing.

Reset
REQ-027 rst_n=0 SHALL asynchronously force a_rdata=0, b_rdata=0, a_rvalid=0, b_rvalid=0, coll=0 and coll_cnt=0.
REQ-028 Reset SHALL NOT clear memory contents.
REQ-029 Writes and reads presented while rst_n=0 SHALL be ignored.
REQ-030 A read in flight when reset asserts SHALL be discarded; no rvalid follows deassertion.
REQ-031 The first accepted operation SHALL be on the first rising edge with rst_n=1.

Configuration
REQ-032 Macro TRUE_DUAL_RAM_OUTREG_EN SHALL control a registered output stage.
REQ-033 When TRUE_DUAL_RAM_OUTREG_EN is defined:
- a second register stage SHALL be placed on rdata and rvalid of each port.
- read latency SHALL be 2 cycles.
- both stages SHALL reset to 0.
- a read issued one cycle before reset asserts SHALL be discarded.
REQ-034 When TRUE_DUAL_RAM_OUTREG_EN is undefined, read latency SHALL be 1 cycle per REQ-018.
REQ-035 The collision logic and its timing SHALL be identical in both configurations.

Verification
REQ-036 Write A addr 0x10 = 0xDEADBEEF with be=0xF; read B addr 0x10 next cycle -> b_rdata=0xDEADBEEF, b_rvalid=1 one cycle later (two with OUTREG).
REQ-037 Preload 0x11223344 at addr 5; write A addr 5 = 0xAABBCCDD with be=0b0101 -> readback 0x11BB33DD.
REQ-038 Same edge: A writes 0xAAAAAAAA, B writes 0x55555555, both at addr 3, a_be=0b0011, b_be=0xF:
- memory = 0x5555AAAA.
- coll=1 for one cycle.
- coll_cnt 0->1.
REQ-039 Preload 0x0 at addr 7; A writes 0x12345678 to addr 7 while B reads addr 7 on the same edge:
- b_rdata=0x0.
- a following read returns 0x12345678.
REQ-040 With CNT_W=2, force 5 collisions -> coll_cnt=3 after the third, and it stays 3.
REQ-041 Assert rst_n=0 mid-read with a read pending -> all outputs 0 immediately, memory retained, no rvalid after release.
